// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic slave backed by a small register-file memory.
// Terminates single accesses with ack after WAIT_STATES cycles, or err when out of range.
module wb_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [15:0]           wr_count_o,
    output logic [15:0]           rd_count_o,
    output logic [15:0]           err_count_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   BASE_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LIMIT_EXT = (ADDR_WIDTH+1)'(BASE_ADDR + DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_W    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [2:0]            WS        = 3'(WAIT_STATES);

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_is_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dat_o;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_err_cnt;

    logic                  w_req;
    logic                  w_in_range;
    logic                  w_commit;
    logic                  w_err_hit;
    logic                  w_acc_we;
    logic [ADDR_WIDTH-1:0] w_acc_adr;
    logic [DATA_WIDTH-1:0] w_acc_dat;
    logic [IDX_W-1:0]      w_idx;

    assign w_req      = cyc_i & stb_i;
    // Extra bit keeps BASE_ADDR+DEPTH from wrapping at the top of the address space.
    assign w_in_range = ({1'b0, adr_i} >= BASE_EXT) && ({1'b0, adr_i} < LIMIT_EXT);

    always_comb begin
        w_next    = r_state;
        w_commit  = 1'b0;
        w_err_hit = 1'b0;
        w_acc_we  = r_we;
        w_acc_adr = r_adr;
        w_acc_dat = r_dat;
        case (r_state)
            ST_IDLE: begin
                // With zero wait states the access commits on the accept edge itself.
                w_acc_we  = we_i;
                w_acc_adr = adr_i;
                w_acc_dat = dat_i;
                if (w_req) begin
                    if (!w_in_range) begin
                        w_next    = ST_RESP;
                        w_err_hit = 1'b1;
                    end else if (WS == 3'd0) begin
                        w_next   = ST_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == 3'd1) begin
                    w_next   = ST_RESP;
                    w_commit = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_idx = IDX_W'(w_acc_adr - BASE_W);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= 3'd0;
            r_adr     <= '0;
            r_we      <= 1'b0;
            r_dat     <= '0;
            r_is_err  <= 1'b0;
            r_dat_o   <= '0;
            r_wr_cnt  <= 16'd0;
            r_rd_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_adr    <= adr_i;
                r_we     <= we_i;
                r_dat    <= dat_i;
                r_is_err <= !w_in_range;
                r_cnt    <= WS;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_commit) begin
                if (w_acc_we) begin
                    r_mem[w_idx] <= w_acc_dat;
                    if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
                end else begin
                    r_dat_o <= r_mem[w_idx];
                    if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end
            if (w_err_hit && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign ack_o       = (r_state == ST_RESP) && !r_is_err;
    assign err_o       = (r_state == ST_RESP) && r_is_err;
    assign dat_o       = r_dat_o;
    assign wr_count_o  = r_wr_cnt;
    assign rd_count_o  = r_rd_cnt;
    assign err_count_o = r_err_cnt;
    assign dbg_state_o = r_state;

endmodule
